dec_rv_ssc_issue_ctl: RTL
=========================

DEC_RV_SSC_ISSUE_CTL -- requirements
Module: dec_rv_ssc_issue_ctl

Interface
REQ-001 SHALL have parameter NLANES, default 3: lanes per fetch group, legal 2..4.
REQ-002 SHALL have parameter EN_XG3, default 1: decode XG3 6-bit register fields when 1.
REQ-003 SHALL have parameter SBD, default 4: scoreboard entries, legal 1..8.
REQ-004 SHALL have parameter LDLAT, default 3: long-latency result delay in cycles, legal 2..7.
REQ-005 SHALL have ports: clock in 1, rising-edge clock; reset in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: in_valid in 1, group present; in_ready out 1, group accepted this cycle.
REQ-007 SHALL have port in_words in 32*NLANES: lane i occupies bits [32i+31:32i].
REQ-008 SHALL have port in_ldmask in NLANES: lane is long-latency (load) when set.
REQ-009 SHALL have ports: out_valid out 1; out_ready in 1; out_count out 3, lanes issued (1..NLANES); out_flag out NLANES-1, bit i-1 set = lane i not co-issued.

Function
REQ-010 SHALL classify a lane as RV when word[1:0]==2'b11, else XG3 (RV when EN_XG3=0).
REQ-011 SHALL take RV fields Rd[11:7], Rs[19:15], Rt[24:20], zero-extended to 6 bits; XG3 fields Rd[11:6], Rs[21:16], Rt[27:22].
REQ-012 SHALL define LoP as id[5:2]==0 and LoPg as LoP with id[1:0]==2'b01.
REQ-013 SHALL block lane i (i>=1) if its Rs or Rt equals Rd of any earlier lane (RAW).
REQ-014 SHALL block lane i if its Rd equals Rd of any earlier lane (WAW).
REQ-015 SHALL block lane i if any earlier lane has Rd/Rs/Rt LoP, lane i has Rd LoP, or lane i has Rs/Rt LoPg.
REQ-016 SHALL block lane i if its RV/XG3 class differs from lane 0.
REQ-017 SHALL block lane i if its Rs or Rt equals any valid scoreboard entry register.
REQ-018 SHALL block lane i if it is a load and free scoreboard entries are fewer than the loads in lanes 0..i.
REQ-019 SHALL set issue count k = 1 + number of consecutive unblocked lanes from lane 1; lanes >=k are not issued.
REQ-020 SHALL stall (in_ready=0) when lane 0 matches REQ-017, or lane 0 is a load and the scoreboard is full.
REQ-021 SHALL drive in_ready = in_valid && !stall && (!out_valid || out_ready), combinationally.
REQ-022 SHALL register k into out_count and the block flags into out_flag on acceptance, with out_valid=1 on the next cycle (latency 1).
REQ-023 SHALL clear out_valid when out_ready=1 and no new group is accepted; SHALL hold out_* stable while out_valid && !out_ready.
REQ-024 SHALL, on acceptance, allocate one entry {Rd, count=LDLAT-1} per issued load lane with Rd!=0, in lowest free slots.
REQ-025 SHALL decrement every valid entry each cycle and free it when count reaches 1; a slot freed this cycle SHALL NOT be reallocated until the next cycle.
REQ-026 SHALL apply decrement before the hazard compare in the same cycle (compare against registered state only).
REQ-027 SHALL ignore Rd/Rs/Rt equal to 0 for REQ-013, REQ-014 and REQ-017.

Reset
REQ-028 SHALL, on reset low, asynchronously clear out_valid, out_count, out_flag and all scoreboard valid bits.
REQ-029 SHALL drive in_ready=0 while reset is low; SHALL discard any in-flight group or pending entry.
REQ-030 SHALL resume normal acceptance on the first rising clock edge after reset deasserts.

Verification
REQ-031 SHALL test: NLANES=3, RV lanes add x10,x11,x12 / add x13,x14,x15 / add x16,x10,x17 -> out_count=2, out_flag=2'b10, one cycle after acceptance.
REQ-032 SHALL test: lane 0 ld x10 issued; next group lane 0 reads x10 -> in_ready=0 for 2 cycles, accepted on cycle 3 (LDLAT=3).
REQ-033 SHALL test: lane 0 RV, lane 1 XG3 word -> out_count=1, out_flag[0]=1.
REQ-034 SHALL test: SBD=1 with one pending load, new group of two independent loads -> stall until free, then out_count=1.
REQ-035 SHALL test: out_ready=0 with out_valid=1 -> in_ready=0, out_* unchanged for 5 cycles; out_ready=1 -> next group accepted same cycle.
REQ-036 SHALL test: reset low during a pending-load stall -> out_valid=0, scoreboard empty, first group after release accepted with no stall.

Source files
------------

// File: rtl/dec_rv_ssc_issue_ctl_if.sv
// Issue-control handshake bundle: fetch-group input side and issue-result output side.
// master = upstream/consumer view, slave = issue controller view.
// Width of the group bus follows NLANES (32 bits per lane).
interface dec_rv_ssc_issue_ctl_if #(
  parameter int NLANES = 3
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [32*NLANES-1:0]  in_words;
  logic [NLANES-1:0]     in_ldmask;
  logic                  out_valid;
  logic                  out_ready;
  logic [2:0]            out_count;
  logic [NLANES-2:0]     out_flag;

  modport master (
    output in_valid, in_words, in_ldmask, out_ready,
    input  in_ready, out_valid, out_count, out_flag
  );

  modport slave (
    input  in_valid, in_words, in_ldmask, out_ready,
    output in_ready, out_valid, out_count, out_flag
  );
endinterface

// File: rtl/dec_rv_ssc_issue_ctl.sv
// Multi-lane issue controller: finds how many leading lanes of a fetch group can co-issue.
// Latency 1: count/flags are registered on acceptance, out_valid the following cycle.
// Backpressure: in_ready drops on a lane-0 scoreboard hazard/full scoreboard or a held output.
module dec_rv_ssc_issue_ctl #(
  parameter int NLANES = 3,
  parameter int EN_XG3 = 1,
  parameter int SBD    = 4,
  parameter int LDLAT  = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  dec_rv_ssc_issue_ctl_if.slave bus
);

  logic [5:0]        rd [NLANES];
  logic [5:0]        rs [NLANES];
  logic [5:0]        rt [NLANES];
  logic [NLANES-1:0] is_rv;
  logic [NLANES-1:0] sb_hit;
  logic [NLANES-1:0] blk;
  logic [NLANES-1:0] issue;
  logic [3:0]        free_cnt;
  logic [3:0]        ld_cnt;
  logic              lop_prev;
  logic              run;
  logic [2:0]        k;
  logic              stall;
  logic              accept;
  logic              found;

  logic [SBD-1:0]    sb_vld;
  logic [5:0]        sb_reg [SBD];
  logic [2:0]        sb_cnt [SBD];
  logic [SBD-1:0]    alloc_en;
  logic [5:0]        alloc_reg [SBD];

  // Low registers x0..x3 are treated specially for pairing.
  function automatic logic is_lop(input logic [5:0] id);
    return id[5:2] == 4'd0;
  endfunction

  function automatic logic is_lopg(input logic [5:0] id);
    return is_lop(id) && (id[1:0] == 2'b01);
  endfunction

  // Per-lane class and register field decode.
  always_comb begin
    for (int i = 0; i < NLANES; i++) begin
      is_rv[i] = (EN_XG3 == 0) || (bus.in_words[32*i +: 2] == 2'b11);
      if (is_rv[i]) begin
        rd[i] = {1'b0, bus.in_words[32*i+7  +: 5]};
        rs[i] = {1'b0, bus.in_words[32*i+15 +: 5]};
        rt[i] = {1'b0, bus.in_words[32*i+20 +: 5]};
      end else begin
        rd[i] = bus.in_words[32*i+6  +: 6];
        rs[i] = bus.in_words[32*i+16 +: 6];
        rt[i] = bus.in_words[32*i+22 +: 6];
      end
    end
  end

  // Scoreboard lookup against registered state only (this cycle's decrement is not visible).
  always_comb begin
    free_cnt = '0;
    for (int j = 0; j < SBD; j++) begin
      if (!sb_vld[j]) free_cnt = free_cnt + 4'd1;
    end
    for (int i = 0; i < NLANES; i++) begin
      sb_hit[i] = 1'b0;
      for (int j = 0; j < SBD; j++) begin
        if (sb_vld[j] && (((rs[i] != 6'd0) && (rs[i] == sb_reg[j])) ||
                          ((rt[i] != 6'd0) && (rt[i] == sb_reg[j]))))
          sb_hit[i] = 1'b1;
      end
    end
  end

  // Per-lane block conditions against earlier lanes, class, scoreboard and load capacity.
  always_comb begin
    blk      = '0;
    ld_cnt   = {3'b000, bus.in_ldmask[0]};
    lop_prev = 1'b0;
    for (int i = 1; i < NLANES; i++) begin
      lop_prev = lop_prev | is_lop(rd[i-1]) | is_lop(rs[i-1]) | is_lop(rt[i-1]);
      ld_cnt   = ld_cnt + {3'b000, bus.in_ldmask[i]};
      if (lop_prev || is_lop(rd[i]) || is_lopg(rs[i]) || is_lopg(rt[i])) blk[i] = 1'b1;
      if (is_rv[i] != is_rv[0]) blk[i] = 1'b1;
      if (sb_hit[i]) blk[i] = 1'b1;
      if (bus.in_ldmask[i] && (free_cnt < ld_cnt)) blk[i] = 1'b1;
      for (int j = 0; j < i; j++) begin
        if ((rs[i] != 6'd0) && (rs[i] == rd[j])) blk[i] = 1'b1;
        if ((rt[i] != 6'd0) && (rt[i] == rd[j])) blk[i] = 1'b1;
        if ((rd[i] != 6'd0) && (rd[i] == rd[j])) blk[i] = 1'b1;
      end
    end
  end

  // Issue window: lane 0 always, then lanes up to the first blocked one.
  always_comb begin
    run      = 1'b1;
    issue    = '0;
    issue[0] = 1'b1;
    k        = 3'd1;
    for (int i = 1; i < NLANES; i++) begin
      run      = run && !blk[i];
      issue[i] = run;
      if (run) k = k + 3'd1;
    end
  end

  assign stall        = sb_hit[0] || (bus.in_ldmask[0] && (free_cnt == 4'd0));
  assign bus.in_ready = rst_n && bus.in_valid && !stall && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_ready;

  // Place each issued load with a nonzero Rd into the lowest slot that was free last cycle.
  always_comb begin
    alloc_en = '0;
    found    = 1'b0;
    for (int j = 0; j < SBD; j++) alloc_reg[j] = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (accept && issue[i] && bus.in_ldmask[i] && (rd[i] != 6'd0)) begin
        found = 1'b0;
        for (int j = 0; j < SBD; j++) begin
          if (!found && !sb_vld[j] && !alloc_en[j]) begin
            alloc_en[j]  = 1'b1;
            alloc_reg[j] = rd[i];
            found        = 1'b1;
          end
        end
      end
    end
  end

  // Output register: load on acceptance, drop valid once consumed, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_count <= '0;
      bus.out_flag  <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_count <= k;
      bus.out_flag  <= ~issue[NLANES-1:1];
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Scoreboard: new loads take free slots; live entries count down and retire at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_vld <= '0;
      for (int j = 0; j < SBD; j++) begin
        sb_reg[j] <= '0;
        sb_cnt[j] <= '0;
      end
    end else begin
      for (int j = 0; j < SBD; j++) begin
        if (alloc_en[j]) begin
          sb_vld[j] <= 1'b1;
          sb_reg[j] <= alloc_reg[j];
          sb_cnt[j] <= 3'(LDLAT - 1);
        end else if (sb_vld[j]) begin
          if (sb_cnt[j] == 3'd1) sb_vld[j] <= 1'b0;
          else                   sb_cnt[j] <= sb_cnt[j] - 3'd1;
        end
      end
    end
  end

  logic unused_sig;
  assign unused_sig = ^{bus.in_words, blk[0], issue[0]};

endmodule
